// File: rtl/wb_shared_bus_ctrl.sv
// Four-master Wishbone shared-bus controller.
// Uses round-robin CYC arbitration with a grant lock and a stall watchdog.
module wb_shared_bus_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  localparam int SW     = DW / 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      M_CYC_I,
  input  logic [3:0]      M_STB_I,
  input  logic [3:0]      M_WE_I,
  input  logic [4*AW-1:0] M_ADR_I,
  input  logic [4*DW-1:0] M_DAT_I,
  input  logic [4*SW-1:0] M_SEL_I,
  output logic [3:0]      M_ACK_O,
  output logic [3:0]      M_ERR_O,
  output logic [DW-1:0]   M_DAT_O,
  output logic            S_CYC_O,
  output logic            S_STB_O,
  output logic            S_WE_O,
  output logic [AW-1:0]   S_ADR_O,
  output logic [DW-1:0]   S_DAT_O,
  output logic [SW-1:0]   S_SEL_O,
  input  logic            S_ACK_I,
  input  logic            S_ERR_I,
  input  logic [DW-1:0]   S_DAT_I,
  output logic [1:0]      GNT,
  output logic            BUSY,
  output logic            WDT_HIT
);

  localparam logic [15:0] WDT_LIM = 16'(TIMEOUT);

  logic        owned_q;
  logic [1:0]  gnt_q;
  logic [1:0]  last_q;
  logic [15:0] wcnt_q, wcnt_d;

  logic        own_cyc;
  logic        arb_edge;
  logic        req_any;
  logic [1:0]  win;
  logic        found;
  logic [1:0]  idx;
  logic        wdt_hit;
  logic        s_cyc;
  logic        s_stb;

  assign own_cyc  = M_CYC_I[gnt_q];
  assign arb_edge = ~owned_q | ~own_cyc;
  assign req_any  = |M_CYC_I;
  assign wdt_hit  = (wcnt_q == WDT_LIM);

  // Search LAST+1 .. LAST+4 (mod 4); LAST itself is the lowest priority.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && M_CYC_I[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign s_cyc = owned_q & own_cyc & ~wdt_hit;
  assign s_stb = s_cyc & M_STB_I[gnt_q];

  always_comb begin
    S_WE_O  = 1'b0;
    S_ADR_O = '0;
    S_DAT_O = '0;
    S_SEL_O = '0;
    for (int i = 0; i < 4; i++) begin
      if (owned_q && gnt_q == 2'(i)) begin
        S_WE_O  = M_WE_I[i];
        S_ADR_O = M_ADR_I[i*AW +: AW];
        S_DAT_O = M_DAT_I[i*DW +: DW];
        S_SEL_O = M_SEL_I[i*SW +: SW];
      end
    end
  end

  always_comb begin
    M_ACK_O = '0;
    M_ERR_O = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_q == 2'(i)) begin
        M_ACK_O[i] = S_ACK_I & s_stb;
        M_ERR_O[i] = (S_ERR_I & s_stb) | wdt_hit;
      end
    end
  end

  // Any strobe that is not stalled restarts the watchdog window.
  always_comb begin
    if (wdt_hit || !s_stb || S_ACK_I || S_ERR_I)
      wcnt_d = '0;
    else
      wcnt_d = wcnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owned_q <= 1'b0;
      gnt_q   <= 2'd0;
      last_q  <= 2'd3;
      wcnt_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      if (arb_edge) begin
        if (req_any) begin
          gnt_q   <= win;
          last_q  <= win;
          owned_q <= 1'b1;
        end else begin
          owned_q <= 1'b0;
        end
      end
    end
  end

  assign S_CYC_O = s_cyc;
  assign S_STB_O = s_stb;
  assign M_DAT_O = S_DAT_I;
  assign GNT     = gnt_q;
  assign BUSY    = owned_q;
  assign WDT_HIT = wdt_hit;

endmodule

// File: tb/tb_wb_shared_bus_ctrl.sv
// Directed bench for wb_shared_bus_ctrl.
// The watchdog limit is set to 8 so that stall tests stay short.
module tb_wb_shared_bus_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    m_cyc, m_stb, m_we;
  logic [127:0]  m_adr, m_dat;
  logic [15:0]   m_sel;
  logic [3:0]    m_ack, m_err;
  logic [31:0]   m_dat_o;
  logic          s_cyc, s_stb, s_we;
  logic [31:0]   s_adr, s_dat_o;
  logic [3:0]    s_sel;
  logic          s_ack, s_err;
  logic [31:0]   s_dat_i;
  logic [1:0]    gnt;
  logic          busy, wdt;

  int total  = 0;
  int passed = 0;

  wb_shared_bus_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .CLK(clk), .RST(rst_n),
    .M_CYC_I(m_cyc), .M_STB_I(m_stb), .M_WE_I(m_we),
    .M_ADR_I(m_adr), .M_DAT_I(m_dat), .M_SEL_I(m_sel),
    .M_ACK_O(m_ack), .M_ERR_O(m_err), .M_DAT_O(m_dat_o),
    .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we),
    .S_ADR_O(s_adr), .S_DAT_O(s_dat_o), .S_SEL_O(s_sel),
    .S_ACK_I(s_ack), .S_ERR_I(s_err), .S_DAT_I(s_dat_i),
    .GNT(gnt), .BUSY(busy), .WDT_HIT(wdt)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, outputs are checked at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    m_adr = '0; m_dat = '0; m_sel = '0;
    s_dat_i = 32'hCAFE_0001;
    tick();
    #1;
    total++;
    if ({s_cyc, s_stb, busy, wdt, gnt} !== 6'b0)
      $display("FAIL reset_ctl got=%b want=000000", {s_cyc, s_stb, busy, wdt, gnt});
    else passed++;
    total++;
    if ({m_ack, m_err} !== 8'h00)
      $display("FAIL reset_resp got=%h want=00", {m_ack, m_err});
    else passed++;
    total++;
    if (m_dat_o !== 32'hCAFE_0001)
      $display("FAIL reset_rdata got=%h want=cafe0001", m_dat_o);
    else passed++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_master();
    int acks;
    acks = 0;
    do_reset();
    m_adr[2*32 +: 32] = 32'h2000_0010;
    m_dat[2*32 +: 32] = 32'h1234_5678;
    m_sel[2*4 +: 4]   = 4'hF;
    m_adr[0 +: 32]    = 32'hDEAD_0000;
    m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100;
    s_ack = 1'b1;
    #1;
    total++;
    if ({busy, s_cyc, m_ack} !== 6'b0)
      $display("FAIL m2_pre got=%b want=000000", {busy, s_cyc, m_ack});
    else passed++;
    s_ack = 1'b0;
    tick();
    #1;
    total++;
    if ({gnt, busy, s_cyc, s_stb, s_we} !== 6'b10_1111)
      $display("FAIL m2_grant got=%b want=101111", {gnt, busy, s_cyc, s_stb, s_we});
    else passed++;
    total++;
    if ({s_adr, s_dat_o, s_sel} !== {32'h2000_0010, 32'h1234_5678, 4'hF})
      $display("FAIL m2_mux got=%h/%h/%h want=20000010/12345678/f", s_adr, s_dat_o, s_sel);
    else passed++;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      s_ack = (c == 3);
      if (c == 4) begin m_cyc = '0; m_stb = '0; end
      #1;
      if (m_ack != 4'b0000) acks++;
      if (c == 3) begin
        total++;
        if (m_ack !== 4'b0100)
          $display("FAIL m2_ack got=%b want=0100", m_ack);
        else passed++;
      end
    end
    total++;
    if (acks !== 1)
      $display("FAIL m2_ack_count got=%0d want=1", acks);
    else passed++;
    total++;
    if ({busy, gnt, s_cyc} !== 4'b0_10_0)
      $display("FAIL m2_release got=%b want=0100", {busy, gnt, s_cyc});
    else passed++;
    idle();
  endtask

  task automatic test_round_robin();
    do_reset();
    m_cyc = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 3) m_cyc[i] = 1'b0;
        #1;
        total++;
        if (gnt !== 2'(i) || busy !== 1'b1 || s_cyc !== (c != 3))
          $display("FAIL rr_m%0d_c%0d got gnt=%0d busy=%b scyc=%b want gnt=%0d busy=1 scyc=%b",
                   i, c, gnt, busy, s_cyc, i, (c != 3));
        else passed++;
        tick();
      end
    end
    #1;
    total++;
    if ({busy, gnt} !== 3'b0_11)
      $display("FAIL rr_idle got=%b want=011", {busy, gnt});
    else passed++;
  endtask

  task automatic test_lock();
    do_reset();
    m_cyc = 4'b0010;
    tick();
    m_cyc = 4'b0011;
    s_ack = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      total++;
      if (gnt !== 2'd1 || m_ack !== 4'b0000)
        $display("FAIL lock_c%0d got gnt=%0d ack=%b want gnt=1 ack=0000", c, gnt, m_ack);
      else passed++;
      tick();
    end
    s_ack = 1'b0;
    m_cyc = 4'b0001;
    #1;
    total++;
    if ({gnt, s_cyc} !== 3'b01_0)
      $display("FAIL lock_drop got=%b want=010", {gnt, s_cyc});
    else passed++;
    tick();
    #1;
    total++;
    if ({gnt, busy, s_cyc} !== 4'b00_11)
      $display("FAIL lock_handoff got=%b want=0011", {gnt, busy, s_cyc});
    else passed++;
    idle();
  endtask

  task automatic test_watchdog();
    do_reset();
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    for (int k = 0; k < 27; k++) begin
      s_ack = (k == 26);
      #1;
      if (k == 8 || k == 17 || k == 26) begin
        total++;
        if ({wdt, s_stb, s_cyc, m_err, m_ack} !== {3'b100, 4'b0010, 4'b0000})
          $display("FAIL wdt_hit_k%0d got=%b want=10000100000",
                   k, {wdt, s_stb, s_cyc, m_err, m_ack});
        else passed++;
      end else if (k == 0 || k == 7 || k == 9 || k == 16) begin
        total++;
        if ({wdt, s_stb, m_err} !== 6'b0_1_0000)
          $display("FAIL wdt_idle_k%0d got=%b want=010000", k, {wdt, s_stb, m_err});
        else passed++;
      end
      tick();
    end
    s_ack = 1'b0;
    s_err = 1'b1;
    #1;
    total++;
    if ({wdt, m_err, m_ack} !== 9'b0_0010_0000)
      $display("FAIL slave_err got=%b want=000100000", {wdt, m_err, m_ack});
    else passed++;
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_adr[3*32 +: 32] = 32'h3000_0004;
    m_cyc = 4'b1000; m_stb = 4'b1000;
    repeat (4) tick();
    #1;
    total++;
    if ({gnt, s_stb, s_adr} !== {2'd3, 1'b1, 32'h3000_0004})
      $display("FAIL m3_stall got=%b/%h want=111/30000004", {gnt, s_stb}, s_adr);
    else passed++;
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    total++;
    if ({s_cyc, s_stb, s_we, busy, wdt, gnt, m_ack, m_err} !== 15'b0
        || s_adr !== 32'h0)
      $display("FAIL reset_mid got=%b adr=%h want=0 adr=0",
               {s_cyc, s_stb, s_we, busy, wdt, gnt, m_ack, m_err}, s_adr);
    else passed++;
    s_ack = 1'b0;
    m_cyc = 4'b1001; m_stb = 4'b1001;
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    total++;
    if ({gnt, busy} !== 3'b00_1)
      $display("FAIL reset_rewin got=%b want=001", {gnt, busy});
    else passed++;
    idle();
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_round_robin();
    test_lock();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_shared_bus_ctrl.md
# wb_shared_bus_ctrl

Shared-bus controller that lets four Wishbone masters share a single Wishbone slave port. It arbitrates `CYC` requests round-robin and locks the grant for the whole bus cycle. It multiplexes the granted master's request signals onto the slave side and routes `ACK`/`ERR`/read data back. A bus watchdog terminates stalled transfers with `ERR`. It sits between the master cluster (DSP core, DMA, host bridge, debug) and the peripheral bus decoder.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8); `SW = DW/8`
- `TIMEOUT`, 255, stalled-strobe cycles before watchdog `ERR` (1..65535)

Ports:
- `CLK` in 1: the single clock, rising edge
- `RST` in 1: asynchronous, active-low reset
- `M_CYC_I` in 4: per-master cycle request
- `M_STB_I` in 4: per-master strobe
- `M_WE_I` in 4: per-master write enable
- `M_ADR_I` in 4*AW: master i in bits [i*AW +: AW]
- `M_DAT_I` in 4*DW: master write data, same packing
- `M_SEL_I` in 4*SW: master byte selects, same packing
- `M_ACK_O` out 4: per-master acknowledge
- `M_ERR_O` out 4: per-master error
- `M_DAT_O` out DW: read data, broadcast to all masters
- `S_CYC_O`, `S_STB_O`, `S_WE_O` out 1 each: slave-side controls
- `S_ADR_O` out AW, `S_DAT_O` out DW, `S_SEL_O` out SW: slave-side request
- `S_ACK_I`, `S_ERR_I` in 1 each; `S_DAT_I` in DW: slave responses
- `GNT` out 2: index of current owner
- `BUSY` out 1: a master owns the bus
- `WDT_HIT` out 1: one-cycle pulse when the watchdog fires

## Operation
- Registered state: `OWNED` (1 bit), `GNT` (2 bits), `LAST` (2 bits, last granted index), watchdog counter `WCNT` (16 bits).
- Arbitration edge: any rising edge where `OWNED=0` or `M_CYC_I[GNT]=0`.
  - At that edge, if any `M_CYC_I` bit is set, the winner is the first requester searching `LAST+1`, `LAST+2`, `LAST+3`, `LAST` (mod 4).
  - Winner is loaded into `GNT` and `LAST`; `OWNED` is set to 1.
  - If no master requests, `OWNED` is set to 0 and `GNT` holds its value.
- Grant lock: while `OWNED=1` and `M_CYC_I[GNT]=1`, no other master can take the bus, regardless of its `CYC`.
- Handoff: when the owner drops `CYC` and others are requesting, the next owner is granted at the same edge. There are no dead cycles.
- Slave-side muxing (combinational): `S_CYC_O = OWNED & M_CYC_I[GNT] & ~WDT_HIT`. `S_STB_O` is `S_CYC_O & M_STB_I[GNT]`. `WE`/`ADR`/`DAT`/`SEL` are taken from the owner's slice, and are 0 when `OWNED=0`.
- Response routing:
  - `M_ACK_O[i] = S_ACK_I & S_STB_O & (GNT==i)`.
  - `M_ERR_O[i] = ((S_ERR_I & S_STB_O) | WDT_HIT) & (GNT==i)`.
  - `M_DAT_O = S_DAT_I`.
  - Slave `ACK`/`ERR` arriving while `S_STB_O=0` is ignored.
- Watchdog:
  - `WCNT` increments each cycle where `S_STB_O=1` and both `S_ACK_I=0` and `S_ERR_I=0`.
  - `WCNT` clears to 0 on `ACK`, on `ERR`, on `S_STB_O=0`, and on `WDT_HIT`.
  - `WDT_HIT = (WCNT == TIMEOUT)` combinational. It masks the slave strobe for that cycle and errors the owner.
- Simultaneous events:
  - Slave `ACK` in the `WDT_HIT` cycle is dropped, because `S_STB_O` is masked; the owner sees only `ERR`.
  - Owner dropping `CYC` in the same cycle the watchdog fires: `ERR` is still routed to `GNT` for that cycle.

## Timing
- Reset (`RST=0`, asynchronous): `OWNED=0`, `GNT=0`, `LAST=3` (master 0 wins first), `WCNT=0`.
  - All `S_*_O`, `M_ACK_O`, `M_ERR_O`, `BUSY`, `WDT_HIT` are 0.
  - `M_DAT_O` follows `S_DAT_I`.
  - Reset mid-transfer aborts the transfer immediately; no `ACK` or `ERR` is issued.
- Grant latency: `CYC` seen at edge k gives `GNT` and `BUSY` valid after edge k. `S_CYC_O` is asserted in the cycle following edge k.
- Release: the owner drops `CYC` in cycle n; `S_CYC_O` falls in the same cycle n (combinational). A new grant becomes effective after the edge ending cycle n.
- `ACK`/`ERR`/data path master↔slave adds no registered latency.
- Watchdog: strobe stalled from cycle s; `WDT_HIT` occurs in cycle s+TIMEOUT.
- `BUSY = OWNED`, registered.

## Test plan
- Master 2 alone raises `CYC`+`STB`, slave `ACK`s after 3 cycles -> `GNT=2`, `S_ADR_O` equals master 2's address, `M_ACK_O=4'b0100` for exactly one cycle.
- All four raise `CYC` at once from reset, each holding it for 4 cycles then dropping -> grant order 0,1,2,3 with no gap cycles between owners.
- Master 1 owns the bus for 10 cycles while master 0 requests -> `GNT` stays 1 until master 1 drops `CYC`, then `GNT=0` at the next edge.
- `TIMEOUT=8`, slave never acknowledges -> `WDT_HIT` and `M_ERR_O[GNT]` pulse in the 8th stalled cycle with `S_STB_O=0`; counter restarts if the master keeps `STB` asserted.
- Slave `ACK` coinciding with `WDT_HIT` -> only `ERR` is delivered; no `ACK` reaches the owner.
- `RST` asserted mid-transfer while master 3 is stalled -> all outputs go to 0 immediately; after release, master 0 wins if requesting together with master 3.
